// File: rtl/regfile_pkg.sv
// Shared widths, the hard-wired zero register and the write-back request type
// used by the register-file write-back arbiter.
package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0] rf_data_t;

  typedef struct packed {
    rf_addr_t addr;
    rf_data_t data;
  } wb_req_t;
endpackage

// File: rtl/wb_rr_pick.sv
// Combinational one-hot grant: first valid requester at or after i_ptr, wrapping.
// All rotations are built at elaboration time so the search is a pure mux.
module wb_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [PTR_W-1:0]   i_ptr,
  input  logic               i_hold,
  output logic [NUM_REQ-1:0] o_grant
);
  logic [NUM_REQ-1:0][NUM_REQ-1:0] w_rot_opt;
  logic [NUM_REQ-1:0][NUM_REQ-1:0] w_gnt_opt;
  logic [NUM_REQ-1:0]              w_rot;
  logic [NUM_REQ-1:0]              w_rot_gnt;

  // Bit gi of rotation r looks at requester (gi + r) mod NUM_REQ.
  generate
    for (genvar gr = 0; gr < NUM_REQ; gr++) begin : g_rot
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bit
        assign w_rot_opt[gr][gi] = i_valid[(gi + gr) % NUM_REQ];
        assign w_gnt_opt[gr][(gi + gr) % NUM_REQ] = w_rot_gnt[gi];
      end
    end
  endgenerate

  assign w_rot     = w_rot_opt[i_ptr];
  assign w_rot_gnt = w_rot & (~w_rot + NUM_REQ'(1));
  assign o_grant   = w_gnt_opt[i_ptr] & {NUM_REQ{~i_hold}};
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter driving the register file's single write port.
// Define REGFILE_WB_FIXED_PRIO_EN for fixed priority (requester 0 highest, no pointer).
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = regfile_pkg::ADDR_W,
  parameter int DATA_W  = regfile_pkg::DATA_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             hold,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rf_wr_en,
  output logic [ADDR_W-1:0]                rf_wr_addr,
  output logic [DATA_W-1:0]                rf_wr_data
);
  import regfile_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [PTR_W-1:0]                 w_ptr;
  logic [NUM_REQ-1:0]               w_grant;
  logic                             w_xfer;
  logic [NUM_REQ:0][ADDR_W-1:0]     w_acc_addr;
  logic [NUM_REQ:0][DATA_W-1:0]     w_acc_data;
  logic                             r_wr_en;
  logic [ADDR_W-1:0]                r_wr_addr;
  logic [DATA_W-1:0]                r_wr_data;

  wb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (w_ptr),
    .i_hold  (hold),
    .o_grant (w_grant)
  );

  // Grant is one-hot, so an AND-OR chain is enough to select the winner.
  assign w_acc_addr[0] = '0;
  assign w_acc_data[0] = '0;
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign w_acc_addr[gi+1] = w_acc_addr[gi] | (req_addr[gi] & {ADDR_W{w_grant[gi]}});
      assign w_acc_data[gi+1] = w_acc_data[gi] | (req_data[gi] & {DATA_W{w_grant[gi]}});
    end
  endgenerate

  assign w_xfer    = |w_grant;
  assign req_ready = w_grant & {NUM_REQ{~rst}};

`ifdef REGFILE_WB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [NUM_REQ:0][PTR_W-1:0] w_acc_idx;
  logic [PTR_W-1:0]            r_ptr;

  assign w_acc_idx[0] = '0;
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_idx
      assign w_acc_idx[gi+1] = w_acc_idx[gi] | (w_grant[gi] ? PTR_W'(gi) : '0);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_acc_idx[NUM_REQ] == PTR_W'(NUM_REQ - 1)) ? '0
             : w_acc_idx[NUM_REQ] + PTR_W'(1);
    end
  end

  assign w_ptr = r_ptr;
`endif

  // Zero-register writes complete the handshake but never raise the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_xfer && (w_acc_addr[NUM_REQ] != ZERO_ADDR);
      if (w_xfer) begin
        r_wr_addr <= w_acc_addr[NUM_REQ];
        r_wr_data <= w_acc_data[NUM_REQ];
      end
    end
  end

  assign rf_wr_en   = r_wr_en;
  assign rf_wr_addr = r_wr_addr;
  assign rf_wr_data = r_wr_data;
endmodule
